// File: rtl/rf_access_seq_if.sv
// -----------------------------------------------------------------------------
// rf_access_seq_if
//   Bundles the requester side (writeback, operand read, operand response) and
//   the register-file side (shared single port) of the rf_access_seq sequencer.
//
//   Parameters:
//     WORD_SIZE  data width
//     REG_COUNT  number of registers; AW = $clog2(REG_COUNT)
//
//   Modports:
//     slave   - the sequencer: takes requests, returns operands, drives the RF port
//     master  - the environment: core decode/execute plus the register file
// -----------------------------------------------------------------------------
interface rf_access_seq_if #(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32
);
  localparam int AW = $clog2(REG_COUNT);

  // Writeback request channel
  logic                 wr_valid;
  logic                 wr_ready;
  logic [AW-1:0]        wr_addr;
  logic [WORD_SIZE-1:0] wr_data;

  // Operand-read request channel
  logic                 rd_req_valid;
  logic                 rd_req_ready;
  logic [AW-1:0]        rd_rs1;
  logic [AW-1:0]        rd_rs2;

  // Operand response channel
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_rs1_data;
  logic [WORD_SIZE-1:0] rsp_rs2_data;

  // Single-port register file access
  logic                 rf_we;
  logic [AW-1:0]        rf_addr;
  logic [WORD_SIZE-1:0] rf_wdata;
  logic [WORD_SIZE-1:0] rf_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_req_valid, rd_rs1, rd_rs2,
    input  rsp_ready,
    input  rf_rdata,
    output wr_ready, rd_req_ready,
    output rsp_valid, rsp_rs1_data, rsp_rs2_data,
    output rf_we, rf_addr, rf_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_req_valid, rd_rs1, rd_rs2,
    output rsp_ready,
    output rf_rdata,
    input  wr_ready, rd_req_ready,
    input  rsp_valid, rsp_rs1_data, rsp_rs2_data,
    input  rf_we, rf_addr, rf_wdata
  );
endinterface

// File: rtl/rf_access_seq.sv
// -----------------------------------------------------------------------------
// rf_access_seq
//   Initiator-side sequencer for a single-port register file. Serialises
//   writeback requests and two-operand read requests onto the shared RF port,
//   giving writes priority, and returns both operands together through a
//   valid/ready response.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous, active-high reset
//     bus  - rf_access_seq_if.slave: writeback, read request, response and
//            RF port signals
//
//   Optional feature macro: RF_SEQ_SKIP_X0_EN
//     Defined   - a source register equal to x0 skips its RF port cycle and
//                 its operand loads 0 (latency 3/2/1 for 0/1/2 zero operands).
//     Undefined - every read uses both READ1 and READ2 (latency always 3).
// -----------------------------------------------------------------------------
module rf_access_seq #(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  rf_access_seq_if.slave   bus
);
  localparam int AW = $clog2(REG_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ1,
    S_READ2,
    S_RESP
  } state_t;

  state_t               r_state;
  logic [AW-1:0]        r_rs2;        // second source, needed once READ1 is done
  logic                 r_rf_we;
  logic [AW-1:0]        r_rf_addr;    // also holds the latched wr addr / rs1
  logic [WORD_SIZE-1:0] r_rf_wdata;   // also holds the latched wr data
  logic                 r_rsp_valid;
  logic [WORD_SIZE-1:0] r_rs1_data;
  logic [WORD_SIZE-1:0] r_rs2_data;

  logic w_idle;
  assign w_idle = (r_state == S_IDLE);

  // Request acceptance is only possible in IDLE; a pending write blocks reads.
  assign bus.wr_ready     = w_idle;
  assign bus.rd_req_ready = w_idle & ~bus.wr_valid;

  assign bus.rf_we        = r_rf_we;
  assign bus.rf_addr      = r_rf_addr;
  assign bus.rf_wdata     = r_rf_wdata;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rs1_data = r_rs1_data;
  assign bus.rsp_rs2_data = r_rs2_data;

  // The RF port outputs are registered: each transition loads the values the
  // destination state presents, so the port is glitch-free and idles at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rs2       <= '0;
      r_rf_we     <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_wdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values and the defaults can be safely overridden.
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;

      case (r_state)
        S_IDLE: begin
          if (bus.wr_valid) begin
            // Writes to x0 complete the handshake but never pulse the enable.
            r_rf_we    <= (bus.wr_addr != '0);
            r_rf_addr  <= bus.wr_addr;
            r_rf_wdata <= bus.wr_data;
            r_state    <= S_WRITE;
          end else if (bus.rd_req_valid) begin
            r_rs2 <= bus.rd_rs2;
`ifdef RF_SEQ_SKIP_X0_EN
            if (bus.rd_rs1 == '0) begin
              r_rs1_data <= '0;
              if (bus.rd_rs2 == '0) begin
                r_rs2_data  <= '0;
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
              end else begin
                r_rf_addr <= bus.rd_rs2;
                r_state   <= S_READ2;
              end
            end else begin
              r_rf_addr <= bus.rd_rs1;
              r_state   <= S_READ1;
            end
`else
            r_rf_addr <= bus.rd_rs1;
            r_state   <= S_READ1;
`endif
          end
        end

        S_WRITE: r_state <= S_IDLE;

        S_READ1: begin
          r_rs1_data <= bus.rf_rdata;
`ifdef RF_SEQ_SKIP_X0_EN
          if (r_rs2 == '0) begin
            r_rs2_data  <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_rf_addr <= r_rs2;
            r_state   <= S_READ2;
          end
`else
          r_rf_addr <= r_rs2;
          r_state   <= S_READ2;
`endif
        end

        S_READ2: begin
          r_rs2_data  <= bus.rf_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end

        S_RESP: begin
          // Operand registers are untouched here, so data holds under backpressure.
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/rf_access_seq.md
# rf_access_seq

Initiator-side sequencer for the single-port register file: it turns operand-read requests (two source registers) and writeback requests into a serial series of single-port accesses. It sits between the core's decode/execute logic and the register file. It owns the RF's shared address/write-enable lines, arbitrates writes against reads, and returns both operands together through a valid/ready response.

## Interface
- `WORD_SIZE`, default 32: data width.
- `REG_COUNT`, default 32: number of registers. `AW = $clog2(REG_COUNT)`.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wr_valid` in 1: writeback request.
- `wr_ready` out 1: writeback accepted this cycle.
- `wr_addr` in AW: destination register.
- `wr_data` in WORD_SIZE: data to write.
- `rd_req_valid` in 1: operand-read request.
- `rd_req_ready` out 1: read request accepted this cycle.
- `rd_rs1`, `rd_rs2` in AW each: source registers.
- `rsp_valid` out 1: operands available.
- `rsp_ready` in 1: consumer takes the operands.
- `rsp_rs1_data`, `rsp_rs2_data` out WORD_SIZE each: operand values.
- `rf_we` out 1: RF write enable.
- `rf_addr` out AW: RF shared address.
- `rf_wdata` out WORD_SIZE: RF write data.
- `rf_rdata` in WORD_SIZE: RF read data. It is combinational from `rf_addr` and reads 0 for address 0.

## Operation
- FSM states: IDLE, WRITE, READ1, READ2, RESP.
- **IDLE**
  - `wr_ready = 1`.
  - `rd_req_ready = !wr_valid`, so a write has priority.
  - On a write handshake: latch addr/data, go to WRITE.
  - Otherwise, on a read handshake: latch rs1/rs2, go to READ1.
- **WRITE**
  - `rf_addr` is the latched address and `rf_wdata` the latched data.
  - `rf_we = (latched addr != 0)`: a write to x0 completes its handshake but never pulses `rf_we`.
  - Next state is IDLE.
- **READ1**
  - `rf_addr = rs1_q`.
  - `rf_rdata` is captured into `rsp_rs1_data` at the clock edge.
  - Next state is READ2.
- **READ2**
  - `rf_addr = rs2_q`.
  - The capture goes into `rsp_rs2_data`.
  - Next state is RESP.
- **RESP**
  - `rsp_valid = 1`, and the data registers are held stable.
  - On `rsp_ready`, go to IDLE.
- Outside WRITE: `rf_we = 0`.
- Outside READ1/READ2/WRITE: `rf_addr = 0` and `rf_wdata = 0`.
- `wr_ready` and `rd_req_ready` are 0 in every state except IDLE.
- rs1 == rs2 still takes two port cycles unless the feature below applies.
- A read accepted after a write sees the written value, because writes finish before returning to IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `rf_we = 0`, `rf_addr = 0`, `rf_wdata = 0`;
  - `rsp_valid = 0`, `rsp_rs1_data = 0`, `rsp_rs2_data = 0`;
  - `wr_ready = 1`, `rd_req_ready = !wr_valid`.
- Reset mid-operation:
  - In-flight request is dropped.
  - Latched request and data registers cleared to zero.
  - The cycle after `rst` is sampled high, the block is in IDLE.
- Read latency: with the handshake at edge 0, the block is in READ1 during cycle 1 and READ2 during cycle 2. `rsp_valid` is high from cycle 3.
- Write: handshake at edge 0, then `rf_we` is high for exactly cycle 1. The next request can be accepted in cycle 2.
- Throughput:
  - One read per 4 cycles with `rsp_ready` held high.
  - One write per 2 cycles.
- Backpressure: `rsp_valid` and the data stay constant until `rsp_ready`. No new request is accepted meanwhile.
- `rsp_ready` sampled without `rsp_valid` is ignored.
- Simultaneous `wr_valid` and `rd_req_valid` in IDLE: the write is taken, and the read waits in the requester with valid held.

## Configuration
- `RF_SEQ_SKIP_X0_EN`
  - **Defined:** a source register equal to 0 skips its port cycle and its data register loads 0.
    - From IDLE, rs1 == 0 goes to READ2, or to RESP if rs2 == 0 as well.
    - From READ1, rs2 == 0 goes to RESP.
    - Response latency is 3, 2 or 1 cycles for 0, 1 or 2 zero operands.
  - **Undefined:** every read always takes the READ1 and READ2 cycles, so latency is fixed at 3.

## Test plan
- Write x5 = 0xDEADBEEF, then read rs1 = 5, rs2 = 7 with x7 preloaded to 0x12345678.
  - `rf_we` high one cycle, addr 5.
  - `rsp_valid` at cycle 3 with rs1 = 0xDEADBEEF and rs2 = 0x12345678.
- `wr_valid` (x3 = 0xA5A5A5A5) and `rd_req_valid` (rs1 = rs2 = 3) asserted together in IDLE.
  - Write is accepted first, and `rd_req_ready` is 0 that cycle.
  - Read is accepted 2 cycles later and returns 0xA5A5A5A5 on both operands.
- Write x0 = 0xFFFFFFFF: `wr_ready` handshake completes, `rf_we` never asserts. A subsequent read of rs1 = 0 returns 0.
- Hold `rsp_ready` low for 5 cycles after `rsp_valid`.
  - Data is stable, and both ready outputs stay 0.
  - Release `rsp_ready`: the block is in IDLE the next cycle.
- Assert `rst` during READ2.
  - Next cycle: IDLE, `rsp_valid = 0`, `rsp_rs1_data = 0`, `rf_we = 0`.
  - No response is ever produced for the dropped request.
- With `RF_SEQ_SKIP_X0_EN` defined:
  - rs1 = rs2 = 0 gives `rsp_valid` at cycle 1 with zeros.
  - rs1 = 0, rs2 = 9 gives `rsp_valid` at cycle 2.
